// File: rtl/shift_load_ctrl_if.sv
// Handshake and serial-output bundle for shift_load_ctrl.
//   master : word producer / serial consumer side (drives in_valid, data_in, pause, abort)
//   slave  : sequencer side (drives in_ready, serial_out, ser_valid, busy, done)
interface shift_load_ctrl_if #(
    parameter int unsigned WIDTH = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_in;
    logic             pause;
    logic             abort;
    logic             serial_out;
    logic             ser_valid;
    logic             busy;
    logic             done;

    modport master (
        output in_valid, data_in, pause, abort,
        input  in_ready, serial_out, ser_valid, busy, done
    );

    modport slave (
        input  in_valid, data_in, pause, abort,
        output in_ready, serial_out, ser_valid, busy, done
    );
endinterface

// File: rtl/shift_load_ctrl.sv
// Parallel-load / MSB-first serialiser sequencer.
// Accepts a WIDTH-bit word on a valid/ready handshake, shifts it out one bit
// per clock (holdable with pause, droppable with abort), then pulses done.
// Ports:
//   clk   : clock, all state changes on posedge
//   clear : asynchronous active-low reset
//   bus   : shift_load_ctrl_if.slave (handshake in, serial stream out, status)
module shift_load_ctrl #(
    parameter int unsigned WIDTH = 5
) (
    input  logic              clk,
    input  logic              clear,
    shift_load_ctrl_if.slave  bus
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;

    // State register and registered status outputs.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state, datapath and status decode.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    shreg_d = bus.data_in;
                    cnt_d   = CW'(WIDTH);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bus.abort) begin
                    shreg_d = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (!bus.pause) begin
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end
                    // Last bit is on serial_out this cycle.
                    if (cnt_q == CW'(1)) begin
                        shreg_d = '0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                shreg_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                shreg_d = '0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        // Status flops are loaded from the next state so they track state_q exactly.
        in_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.serial_out = shreg_q[WIDTH-1];
    // ser_valid marks a fresh bit; a paused cycle re-shows the held bit, so it
    // has to follow pause within the same cycle.
    assign bus.ser_valid  = (state_q == ST_SHIFT) && !bus.pause;

endmodule

// File: tb/tb_shift_load_ctrl.sv
// Self-checking bench for shift_load_ctrl: directed scenarios followed by
// random stimulus, all compared against a bit-queue reference model.
module tb_shift_load_ctrl;

    localparam int unsigned W = 5;

    logic clk;
    logic clear;

    shift_load_ctrl_if #(.WIDTH(W)) bus ();

    shift_load_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_bad;

    // Reference model: bits still to present (front = bit on serial_out),
    // whether the block is idle, and whether this is the done cycle.
    bit m_bits[$];
    bit m_idle;
    bit m_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_idle = 1'b1;
        m_done = 1'b0;
    endtask

    task automatic check_outputs(input logic p);
        logic exp_so;
        exp_so = (m_bits.size() > 0) ? m_bits[0] : 1'b0;
        chk("in_ready",   32'(bus.in_ready),   32'(m_idle));
        chk("busy",       32'(bus.busy),       32'(!m_idle));
        chk("done",       32'(bus.done),       32'(m_done));
        chk("serial_out", 32'(bus.serial_out), 32'(exp_so));
        chk("ser_valid",  32'(bus.ser_valid),  32'(m_bits.size() > 0 && !p));
    endtask

    // Called at posedge+1: apply inputs, check mid-cycle, then advance model.
    task automatic step(input logic v, input logic [W-1:0] d, input logic p, input logic a);
        bus.in_valid = v;
        bus.data_in  = d;
        bus.pause    = p;
        bus.abort    = a;
        @(negedge clk);
        check_outputs(p);
        @(posedge clk);
        #1;
        if (m_done) begin
            m_done = 1'b0;
            m_idle = 1'b1;
        end else if (m_idle) begin
            if (v) begin
                for (int i = W - 1; i >= 0; i--) m_bits.push_back(d[i]);
                m_idle = 1'b0;
            end
        end else if (a) begin
            m_bits.delete();
            m_idle = 1'b1;
        end else if (!p) begin
            void'(m_bits.pop_front());
            if (m_bits.size() == 0) m_done = 1'b1;
        end
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"},   32'(bus.in_ready),   32'd1);
        chk({tag, "_busy"},       32'(bus.busy),       32'd0);
        chk({tag, "_serial_out"}, 32'(bus.serial_out), 32'd0);
        chk({tag, "_done"},       32'(bus.done),       32'd0);
        chk({tag, "_ser_valid"},  32'(bus.ser_valid),  32'd0);
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        model_reset();
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        bus.data_in  = '0;
        bus.pause    = 1'b0;
        bus.abort    = 1'b0;

        // Reset held for two cycles.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values("rst");
        clear = 1'b1;
        @(posedge clk);
        #1;

        // Plain word.
        step(1'b1, 5'b10110, 1'b0, 1'b0);
        idle_steps(8);

        // Same word, two-cycle pause after the second bit.
        step(1'b1, 5'b10110, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        idle_steps(6);

        // Abort during the third bit.
        step(1'b1, 5'b11111, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        idle_steps(3);

        // Back-to-back words with in_valid held high.
        step(1'b1, 5'b00001, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) step(1'b1, 5'b10000, 1'b0, 1'b0);
        idle_steps(3);

        // Asynchronous reset between edges in the middle of a word.
        step(1'b1, 5'b11011, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        clear = 1'b0;
        #2;
        check_reset_values("arst");
        model_reset();
        @(negedge clk);
        check_reset_values("arst_hold");
        clear = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 5'b01101, 1'b0, 1'b0);
        idle_steps(7);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)),
                 W'($urandom),
                 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 15) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
